mem_pipe_ctrl: RTL



---
 rtl/mem_pipe_ctrl_pkg.sv | 21 ++
 rtl/mem_pipe_perf.sv | 26 ++
 rtl/mem_pipe_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_pipe_ctrl_pkg.sv
// Shared types and limits for the back-end pipeline stall/flush scheduler.
package mem_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DC_WAIT   = 2'd1,
        EXC_DRAIN = 2'd2
    } pipe_ctrl_state_e;

    typedef struct packed {
        logic wr;
        logic flush;
    } stage_ctrl_t;

    localparam int EXC_DRAIN_MAX = 7;
    localparam int DRAIN_CNT_W   = 3;

    localparam stage_ctrl_t STAGE_ADVANCE = '{wr: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STAGE_RESET   = '{wr: 1'b0, flush: 1'b1};

endpackage

// File: rtl/mem_pipe_perf.sv
// D-cache stall and exception counters; only built when MEM_PIPE_PERF_EN is defined.
module mem_pipe_perf #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dc_stall,
    input  logic              exc_taken,
    output logic [PERF_W-1:0] perf_dc_stall,
    output logic [PERF_W-1:0] perf_exc_cnt
);

    // Both counters wrap naturally at 2^PERF_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_dc_stall <= '0;
            perf_exc_cnt  <= '0;
        end else begin
            if (dc_stall)
                perf_dc_stall <= perf_dc_stall + PERF_W'(1);
            if (exc_taken)
                perf_exc_cnt <= perf_exc_cnt + PERF_W'(1);
        end
    end

endmodule

// File: rtl/mem_pipe_ctrl.sv
// Stall/flush scheduler for PC..WB stage registers (D-cache miss, exception redirect/drain, hazards).
// Optional performance counters under `define MEM_PIPE_PERF_EN.
module mem_pipe_ctrl
    import mem_pipe_ctrl_pkg::*;
#(
    parameter int EXC_DRAIN_CYCLES = 1,
    parameter int PERF_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_ICacheBusy,
    input  logic              ID_LoadUse,
    input  logic              EXE_DivBusy,
    input  logic              MEM_ExcValid,
    input  logic              MEM2_DCacheBusy,
    output logic              PC_Wr,
    output logic              ID_Wr,
    output logic              EXE_Wr,
    output logic              MEM_Wr,
    output logic              MEM2_Wr,
    output logic              WB_Wr,
    output logic              ID_Flush,
    output logic              EXE_Flush,
    output logic              MEM_Flush,
    output logic              MEM2_Flush,
    output logic              WB_Flush,
    output logic              PC_Redirect,
    output logic [PERF_W-1:0] Perf_DCStall,
    output logic [PERF_W-1:0] Perf_ExcCnt
);

    localparam int DRAIN_CLAMP = (EXC_DRAIN_CYCLES > EXC_DRAIN_MAX) ? EXC_DRAIN_MAX :
                                 (EXC_DRAIN_CYCLES < 1) ? 1 : EXC_DRAIN_CYCLES;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CLAMP);

    pipe_ctrl_state_e        state, state_nxt;
    logic [DRAIN_CNT_W-1:0]  drain_cnt, drain_cnt_nxt;
    logic                    pc_wr, redirect;
    stage_ctrl_t             id_c, exe_c, mem_c, mem2_c, wb_c;

    always_comb begin
        pc_wr         = 1'b1;
        id_c          = STAGE_ADVANCE;
        exe_c         = STAGE_ADVANCE;
        mem_c         = STAGE_ADVANCE;
        mem2_c        = STAGE_ADVANCE;
        wb_c          = STAGE_ADVANCE;
        redirect      = 1'b0;
        state_nxt     = RUN;
        drain_cnt_nxt = '0;

        if (!rst) begin
            pc_wr  = 1'b0;
            id_c   = STAGE_RESET;
            exe_c  = STAGE_RESET;
            mem_c  = STAGE_RESET;
            mem2_c = STAGE_RESET;
            wb_c   = STAGE_RESET;
        end else if (MEM2_DCacheBusy) begin
            // Freeze everything up to MEM2; WB gets a bubble so nothing retires twice.
            pc_wr       = 1'b0;
            id_c.wr     = 1'b0;
            exe_c.wr    = 1'b0;
            mem_c.wr    = 1'b0;
            mem2_c.wr   = 1'b0;
            wb_c.flush  = 1'b1;
            state_nxt   = DC_WAIT;
        end else if (MEM_ExcValid) begin
            // Excepting instruction moves on into MEM2; younger ones are squashed.
            id_c.flush    = 1'b1;
            exe_c.flush   = 1'b1;
            mem_c.flush   = 1'b1;
            redirect      = 1'b1;
            state_nxt     = EXC_DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
        end else begin
            if (EXE_DivBusy) begin
                pc_wr       = 1'b0;
                id_c.wr     = 1'b0;
                exe_c.wr    = 1'b0;
                mem_c.flush = 1'b1;
            end else if (ID_LoadUse) begin
                pc_wr       = 1'b0;
                id_c.wr     = 1'b0;
                exe_c.flush = 1'b1;
            end else if (IF_ICacheBusy) begin
                pc_wr       = 1'b0;
                id_c.flush  = 1'b1;
            end
            // Fetches issued before the redirect are still arriving; keep dropping them.
            if (state == EXC_DRAIN) begin
                pc_wr      = 1'b1;
                id_c.flush = 1'b1;
                if (drain_cnt > DRAIN_CNT_W'(1)) begin
                    state_nxt     = EXC_DRAIN;
                    drain_cnt_nxt = drain_cnt - DRAIN_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    assign PC_Wr       = pc_wr;
    assign ID_Wr       = id_c.wr;
    assign EXE_Wr      = exe_c.wr;
    assign MEM_Wr      = mem_c.wr;
    assign MEM2_Wr     = mem2_c.wr;
    assign WB_Wr       = wb_c.wr;
    assign ID_Flush    = id_c.flush;
    assign EXE_Flush   = exe_c.flush;
    assign MEM_Flush   = mem_c.flush;
    assign MEM2_Flush  = mem2_c.flush;
    assign WB_Flush    = wb_c.flush;
    assign PC_Redirect = redirect;

`ifdef MEM_PIPE_PERF_EN
    mem_pipe_perf #(
        .PERF_W(PERF_W)
    ) u_perf (
        .clk           (clk),
        .rst           (rst),
        .dc_stall      (MEM2_DCacheBusy),
        .exc_taken     (redirect),
        .perf_dc_stall (Perf_DCStall),
        .perf_exc_cnt  (Perf_ExcCnt)
    );
`else
    assign Perf_DCStall = '0;
    assign Perf_ExcCnt  = '0;
`endif

endmodule
